phase_bank_ctrl: RTL and testbench

Double-buffered phase bank controller between the host command path and the per-channel `pwm` instances. Accepts per-channel phase writes into a shadow bank and, on a commit command, copies the whole shadow bank into the active bank exactly on a PWM period boundary. This gives all transducers a new phase pattern atomically, with no mid-period tearing. Runs entirely in the PWM clock domain; command words arrive already synchronized.

---
 rtl/phase_bank_pkg.sv | 7 +
 rtl/commit_watchdog.sv | 19 +
 rtl/phase_bank_ctrl.sv | 102 ++++++++++
 tb/tb_phase_bank_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_bank_pkg.sv
// phase_bank_pkg: shared command/state types and widths for the phase bank controller
package phase_bank_pkg;
  typedef enum logic [1:0] {OP_WRITE, OP_COMMIT, OP_CLEAR, OP_RSVD} cmd_op_e;
  typedef enum logic [1:0] {IDLE, CLEARING, COMMIT_WAIT} bank_state_e;
  localparam int CMD_W = 16;
  localparam int FRAME_CNT_W = 16;
endpackage

// File: rtl/commit_watchdog.sv
// commit_watchdog: loadable down-counter that flags when a pending commit has waited too long
module commit_watchdog #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         run,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;
  assign expired = run && cnt == '0;
  // reload on a new commit, otherwise count down while the commit is pending
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (run && cnt != '0) cnt <= cnt - 1'b1;
endmodule

// File: rtl/phase_bank_ctrl.sv
// phase_bank_ctrl: double-buffered phase bank with boundary-aligned atomic commit
module phase_bank_ctrl
  import phase_bank_pkg::*;
#(
  parameter int NUM_CHANNELS = 256,
  parameter int CLK_CNT_W = 8,
  parameter int CLK_CNT_MAX = 249
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CMD_W-1:0]       cmd_data,
  input  logic [CLK_CNT_W-1:0]   pwm_cnt,
  output logic [CLK_CNT_W-1:0]   phases [NUM_CHANNELS],
  output logic                   commit_done,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   cmd_err,
  output logic                   commit_timeout
);
  localparam int WD_LOAD = 2 * (CLK_CNT_MAX + 1);
  localparam int WD_W = $clog2(WD_LOAD + 1);
  localparam int IDX_W = $clog2(NUM_CHANNELS);
  bank_state_e state;
  cmd_op_e op;
  logic [CLK_CNT_W-1:0] shadow [NUM_CHANNELS];
  logic [IDX_W-1:0] idx;
  logic hs, wr_ok, boundary, wd_load, wd_run, expired;
  assign op = cmd_op_e'(cmd_op);
  assign hs = cmd_valid && cmd_ready && state == IDLE;
  assign wr_ok = int'(cmd_data[15:8]) < NUM_CHANNELS && int'(cmd_data[CLK_CNT_W-1:0]) <= CLK_CNT_MAX;
  assign boundary = pwm_cnt == CLK_CNT_W'(CLK_CNT_MAX);
  assign wd_load = hs && op == OP_COMMIT;
  assign wd_run = state == COMMIT_WAIT;
  commit_watchdog #(.W(WD_W)) u_wd (
    .clk(clk),
    .rst(rst),
    .load(wd_load),
    .run(wd_run),
    .load_val(WD_W'(WD_LOAD)),
    .expired(expired)
  );
  // command FSM: shadow writes, sequential clear, and boundary-aligned shadow->active copy
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cmd_ready <= 1'b0;
      commit_done <= 1'b0;
      commit_timeout <= 1'b0;
      cmd_err <= 1'b0;
      frame_cnt <= '0;
      idx <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        shadow[i] <= '0;
        phases[i] <= '0;
      end
    end else begin
      commit_done <= 1'b0;
      commit_timeout <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (hs)
            case (op)
              OP_WRITE:
                if (wr_ok) shadow[cmd_data[15:8]] <= cmd_data[CLK_CNT_W-1:0];
                else cmd_err <= 1'b1;
              OP_COMMIT: begin
                state <= COMMIT_WAIT;
                cmd_ready <= 1'b0;
              end
              OP_CLEAR: begin
                state <= CLEARING;
                idx <= '0;
                cmd_ready <= 1'b0;
              end
              default: cmd_err <= 1'b1;
            endcase
        end
        CLEARING: begin
          shadow[idx] <= '0;
          idx <= idx + 1'b1;
          if (idx == IDX_W'(NUM_CHANNELS - 1)) begin
            state <= IDLE;
            cmd_ready <= 1'b1;
          end
        end
        COMMIT_WAIT:
          if (boundary || expired) begin
            phases <= shadow;
            frame_cnt <= frame_cnt + 1'b1;
            commit_done <= 1'b1;
            commit_timeout <= !boundary;
            state <= IDLE;
            cmd_ready <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_phase_bank_ctrl.sv
// tb_phase_bank_ctrl: random and directed checks of phase_bank_ctrl against a behavioural model
module tb_phase_bank_ctrl;
  logic clk = 0, rst = 1, cmd_valid = 0;
  logic cmd_ready, commit_done, cmd_err, commit_timeout;
  logic [1:0] cmd_op = 0;
  logic [15:0] cmd_data = 0, frame_cnt;
  logic [7:0] pwm_cnt = 0;
  logic [7:0] phases [256];
  int checks = 0, errors = 0;
  bit chk_en = 0, pwm_run = 0;

  phase_bank_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .pwm_cnt(pwm_cnt), .phases(phases),
    .commit_done(commit_done), .frame_cnt(frame_cnt), .cmd_err(cmd_err),
    .commit_timeout(commit_timeout)
  );

  always #5 clk = ~clk;

  // behavioural model: shadow/active arrays plus counters for clear and commit progress
  logic [7:0] m_shadow [256], m_phases [256];
  logic [15:0] m_frame;
  bit m_ready, e_done, e_err, e_to, waiting;
  int clear_left, age;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        m_shadow[i] = 0;
        m_phases[i] = 0;
      end
      m_ready = 0; m_frame = 0; e_done = 0; e_err = 0; e_to = 0;
      waiting = 0; clear_left = 0; age = 0;
    end else begin
      e_done = 0; e_err = 0; e_to = 0;
      if (clear_left > 0) begin
        m_shadow[256 - clear_left] = 0;
        clear_left--;
        m_ready = (clear_left == 0);
      end else if (waiting) begin
        age++;
        if (pwm_cnt == 249 || age > 500) begin
          m_phases = m_shadow;
          m_frame++;
          e_done = 1;
          e_to = (pwm_cnt != 249);
          waiting = 0;
          m_ready = 1;
        end
      end else if (!m_ready) m_ready = 1;
      else if (cmd_valid)
        case (cmd_op)
          2'd0: if (cmd_data[7:0] <= 249) m_shadow[cmd_data[15:8]] = cmd_data[7:0]; else e_err = 1;
          2'd1: begin waiting = 1; age = 0; m_ready = 0; end
          2'd2: begin clear_left = 256; m_ready = 0; end
          default: e_err = 1;
        endcase
    end
  end

  task automatic cmp(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clk) if (!rst && chk_en) begin
    int bad;
    cmp("cmd_ready", int'(cmd_ready), int'(m_ready));
    cmp("commit_done", int'(commit_done), int'(e_done));
    cmp("cmd_err", int'(cmd_err), int'(e_err));
    cmp("commit_timeout", int'(commit_timeout), int'(e_to));
    cmp("frame_cnt", int'(frame_cnt), int'(m_frame));
    bad = -1;
    for (int i = 0; i < 256; i++) if (bad < 0 && phases[i] != m_phases[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL phases[%0d]: got %0d expected %0d at %0t", bad, phases[bad], m_phases[bad], $time);
    end
  end

  task automatic tick();
    @(negedge clk);
    if (pwm_run) pwm_cnt = (pwm_cnt == 249) ? 8'd0 : pwm_cnt + 8'd1;
  endtask

  task automatic send(input logic [1:0] op, input logic [15:0] d);
    bit hs = 0;
    cmd_valid = 1; cmd_op = op; cmd_data = d;
    for (int i = 0; i < 2000 && !hs; i++) begin
      hs = cmd_ready;
      tick();
    end
    cmd_valid = 0;
    if (!hs) cmp("handshake_timeout", 0, 1);
  endtask

  task automatic pulse_rst();
    #2 rst = 1;
    #10 rst = 0;
    tick();
  endtask

  initial begin
    int k;
    #22 rst = 0;
    tick();
    chk_en = 1;
    cmp("reset_ready", int'(cmd_ready), 1);
    cmp("reset_frame", int'(frame_cnt), 0);
    cmp("reset_phase0", int'(phases[0]), 0);
    cmp("model_reset_ready", int'(m_ready), 1);
    // write + commit with a running PWM counter
    pwm_run = 1;
    send(2'd0, {8'd5, 8'd100});
    send(2'd0, {8'd255, 8'd249});
    for (int i = 0; i < 300 && pwm_cnt != 10; i++) tick();
    send(2'd1, 16'd0);
    k = 0;
    while (!commit_done && k < 1000) begin
      cmp("phase5_before_commit", int'(phases[5]), 0);
      tick();
      k++;
    end
    cmp("commit_latency", k, 239);
    cmp("ch5", int'(phases[5]), 100);
    cmp("ch255", int'(phases[255]), 249);
    cmp("ch0", int'(phases[0]), 0);
    cmp("frame_after_commit", int'(frame_cnt), 1);
    tick();
    cmp("done_one_cycle", int'(commit_done), 0);
    // out-of-range phase and reserved op
    send(2'd0, {8'd3, 8'd250});
    cmp("err_bad_phase", int'(cmd_err), 1);
    send(2'd3, 16'h1234);
    cmp("err_rsvd", int'(cmd_err), 1);
    send(2'd1, 16'd0);
    for (int i = 0; i < 600 && !commit_done; i++) tick();
    cmp("ch3_unchanged", int'(phases[3]), 0);
    cmp("ch5_kept", int'(phases[5]), 100);
    // fill everything with 0x20, clear, then commit zeros
    for (int c = 0; c < 256; c++) send(2'd0, {8'(c), 8'h20});
    send(2'd1, 16'd0);
    for (int i = 0; i < 600 && !commit_done; i++) tick();
    cmp("filled_ch17", int'(phases[17]), 32);
    tick();
    send(2'd2, 16'd0);
    k = 0;
    while (!cmd_ready && k < 1000) begin
      tick();
      k++;
    end
    cmp("clear_busy_cycles", k, 256);
    cmp("clear_keeps_active", int'(phases[200]), 32);
    send(2'd1, 16'd0);
    for (int i = 0; i < 600 && !commit_done; i++) tick();
    cmp("cleared_ch17", int'(phases[17]), 0);
    // stalled PWM forces a timeout commit
    tick();
    pwm_run = 0; pwm_cnt = 0;
    send(2'd0, {8'd9, 8'd77});
    send(2'd1, 16'd0);
    k = 0;
    while (!commit_done && k < 1000) begin
      tick();
      k++;
    end
    cmp("timeout_latency", k, 501);
    cmp("timeout_pulse", int'(commit_timeout), 1);
    cmp("timeout_ch9", int'(phases[9]), 77);
    // randomized traffic
    pwm_run = 1;
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 99);
      if (r < 70) send(2'd0, {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
      else if (r < 84) send(2'd1, 16'($urandom));
      else if (r < 88) send(2'd2, 16'($urandom));
      else if (r < 94) send(2'd3, 16'($urandom));
      else repeat ($urandom_range(1, 20)) tick();
      if (n == 200) pwm_run = 0;
      if (n == 230) pwm_run = 1;
    end
    // reset during COMMIT_WAIT
    pwm_run = 0; pwm_cnt = 0;
    for (int i = 0; i < 600 && !cmd_ready; i++) tick();
    send(2'd0, {8'd1, 8'd50});
    send(2'd1, 16'd0);
    repeat (20) tick();
    pulse_rst();
    cmp("rst_commit_ready", int'(cmd_ready), 1);
    cmp("rst_commit_frame", int'(frame_cnt), 0);
    cmp("rst_commit_ch1", int'(phases[1]), 0);
    k = 0;
    repeat (600) begin
      tick();
      k += int'(commit_done);
    end
    cmp("rst_commit_no_done", k, 0);
    // reset during CLEARING
    send(2'd2, 16'd0);
    repeat (50) tick();
    pulse_rst();
    cmp("rst_clear_ready", int'(cmd_ready), 1);
    cmp("rst_clear_frame", int'(frame_cnt), 0);
    k = 0;
    repeat (300) begin
      tick();
      k += int'(commit_done);
    end
    cmp("rst_clear_no_done", k, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
